// File: rtl/trail_pkg.sv
// rtl/trail_pkg.sv - shared constants, enums and cell-address helper for the trail collision checker
package trail_pkg;

  localparam logic [2:0]  PLAY_STATE = 3'b010;
  localparam int          PLAY_MAX   = 223;
  localparam logic [19:0] ROW_STRIDE = 20'd1280;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [3:0] {
    TRAIL_NONE = 4'd0,
    B_HORIZ    = 4'd1,
    B_VERT     = 4'd2,
    R_HORIZ    = 4'd3,
    R_VERT     = 4'd4,
    CORNER     = 4'd5
  } trail_t;

  // Word address of a cell: two words per column, ROW_STRIDE words per row.
  function automatic logic [19:0] cell_addr(input logic [7:0] x, input logic [7:0] y);
    return {11'd0, x, 1'b0} + ({12'd0, y} * ROW_STRIDE);
  endfunction

endpackage

// File: rtl/trail_probe.sv
// rtl/trail_probe.sv - combinational next-cell probe: head + direction -> probe cell, wall test, address
module trail_probe
  import trail_pkg::*;
(
  input  logic [7:0]        head_x,
  input  logic [7:0]        head_y,
  input  logic [1:0]        dir,
  output logic signed [8:0] probe_x,
  output logic signed [8:0] probe_y,
  output logic              out_of_bounds,
  output logic [19:0]       addr
);

  localparam logic signed [8:0] MAX_COORD = 9'(PLAY_MAX);

  logic signed [8:0] hx;
  logic signed [8:0] hy;

  assign hx = $signed({1'b0, head_x});
  assign hy = $signed({1'b0, head_y});

  // Move the head one cell along its direction; 9-bit signed so stepping off the top/left goes negative.
  always_comb begin
    probe_x = hx;
    probe_y = hy;
    case (dir)
      DIR_UP:    probe_y = hy - 9'sd1;
      DIR_DOWN:  probe_y = hy + 9'sd1;
      DIR_LEFT:  probe_x = hx - 9'sd1;
      default:   probe_x = hx + 9'sd1;
    endcase
  end

  assign out_of_bounds = (probe_x < 9'sd0) || (probe_x > MAX_COORD) ||
                         (probe_y < 9'sd0) || (probe_y > MAX_COORD);

  // Only meaningful when the probe is on the field, where the low 8 bits are the true coordinate.
  assign addr = cell_addr(probe_x[7:0], probe_y[7:0]);

endmodule

// File: rtl/trail_collision.sv
// rtl/trail_collision.sv - per-frame bike collision checker; READ_TIMEOUT_EN adds a read-return timeout
module trail_collision
  import trail_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [2:0]  Game_State,
  input  logic [7:0]  Blue_X,
  input  logic [7:0]  Blue_Y,
  input  logic [7:0]  Red_X,
  input  logic [7:0]  Red_Y,
  input  logic [1:0]  Blue_dir,
  input  logic [1:0]  Red_dir,
  output logic        rd_req,
  input  logic        rd_gnt,
  output logic [19:0] rd_addr,
  input  logic [15:0] rd_data,
  input  logic        rd_valid,
  output logic        collision_blue,
  output logic        collision_red,
  output logic        check_done
);

  typedef enum logic [2:0] {
    IDLE, LATCH, REQ_B, WAIT_B, REQ_R, WAIT_R, RESOLVE, DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic       fsync1, fsync2, fprev;
  logic       frame_rise, in_play, start;
  logic [7:0] lat_bx, lat_by, lat_rx, lat_ry;
  logic [1:0] lat_bdir, lat_rdir;
  logic       occ_b, occ_r;
  logic       cell_hit;
  logic       timeout;
  logic       unused_rd_bits;

  logic signed [8:0] pbx, pby, prx, pry;
  logic              oob_b, oob_r;
  logic [19:0]       addr_b, addr_r;
  logic              same_probe, b_hits_rhead, r_hits_bhead, hit_b, hit_r;

  trail_probe u_probe_blue (
    .head_x        (lat_bx),
    .head_y        (lat_by),
    .dir           (lat_bdir),
    .probe_x       (pbx),
    .probe_y       (pby),
    .out_of_bounds (oob_b),
    .addr          (addr_b)
  );

  trail_probe u_probe_red (
    .head_x        (lat_rx),
    .head_y        (lat_ry),
    .dir           (lat_rdir),
    .probe_x       (prx),
    .probe_y       (pry),
    .out_of_bounds (oob_r),
    .addr          (addr_r)
  );

  assign in_play    = (Game_State == PLAY_STATE);
  assign frame_rise = fsync2 & ~fprev;
  assign start      = (state == IDLE) && frame_rise && in_play;

  // Two-flop synchroniser for the frame tick plus one history flop for edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsync1 <= 1'b0;
      fsync2 <= 1'b0;
      fprev  <= 1'b0;
    end else begin
      fsync1 <= frame_clk;
      fsync2 <= fsync1;
      fprev  <= fsync2;
    end
  end

`ifdef READ_TIMEOUT_EN
  logic [3:0] tmo_cnt;

  // Count consecutive WAIT cycles without a read return; give up on the 15th.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tmo_cnt <= 4'd0;
    end else if ((state == WAIT_B || state == WAIT_R) && !rd_valid && in_play) begin
      tmo_cnt <= tmo_cnt + 4'd1;
    end else begin
      tmo_cnt <= 4'd0;
    end
  end

  assign timeout = (state == WAIT_B || state == WAIT_R) && !rd_valid && (tmo_cnt == 4'd14);
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: blue read first, players whose probe hits a wall skip their read.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LATCH;
      LATCH: begin
        if (!oob_b)      state_nx = REQ_B;
        else if (!oob_r) state_nx = REQ_R;
        else             state_nx = RESOLVE;
      end
      REQ_B:   if (rd_gnt) state_nx = WAIT_B;
      WAIT_B:  if (rd_valid || timeout) state_nx = oob_r ? RESOLVE : REQ_R;
      REQ_R:   if (rd_gnt) state_nx = WAIT_R;
      WAIT_R:  if (rd_valid || timeout) state_nx = RESOLVE;
      RESOLVE: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!in_play) state_nx = IDLE;
  end

  // Snapshot heads and directions when a check starts so mid-check input changes are ignored.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lat_bx   <= 8'd0;
      lat_by   <= 8'd0;
      lat_rx   <= 8'd0;
      lat_ry   <= 8'd0;
      lat_bdir <= 2'd0;
      lat_rdir <= 2'd0;
    end else if (start) begin
      lat_bx   <= Blue_X;
      lat_by   <= Blue_Y;
      lat_rx   <= Red_X;
      lat_ry   <= Red_Y;
      lat_bdir <= Blue_dir;
      lat_rdir <= Red_dir;
    end
  end

  assign cell_hit       = (rd_data[3:0] | rd_data[11:8]) != 4'd0;
  assign unused_rd_bits = ^{rd_data[15:12], rd_data[7:4]};

  // Capture occupancy from the first read return; cleared per check so skipped or aborted reads count as empty.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      occ_b <= 1'b0;
      occ_r <= 1'b0;
    end else if (state == LATCH) begin
      occ_b <= 1'b0;
      occ_r <= 1'b0;
    end else begin
      if (state == WAIT_B && rd_valid) occ_b <= cell_hit;
      if (state == WAIT_R && rd_valid) occ_r <= cell_hit;
    end
  end

  assign same_probe   = (pbx == prx) && (pby == pry);
  assign b_hits_rhead = (pbx == $signed({1'b0, lat_rx})) && (pby == $signed({1'b0, lat_ry}));
  assign r_hits_bhead = (prx == $signed({1'b0, lat_bx})) && (pry == $signed({1'b0, lat_by}));
  assign hit_b        = oob_b | occ_b | same_probe | b_hits_rhead;
  assign hit_r        = oob_r | occ_r | same_probe | r_hits_bhead;

  // Sticky collision flags: set in RESOLVE, cleared only by leaving PLAY or reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      collision_blue <= 1'b0;
      collision_red  <= 1'b0;
    end else if (!in_play) begin
      collision_blue <= 1'b0;
      collision_red  <= 1'b0;
    end else if (state == RESOLVE) begin
      collision_blue <= collision_blue | hit_b;
      collision_red  <= collision_red  | hit_r;
    end
  end

  // Read port and completion pulse decode straight from the registered state.
  always_comb begin
    rd_req     = 1'b0;
    rd_addr    = 20'd0;
    check_done = (state == DONE);
    if (state == REQ_B) begin
      rd_req  = 1'b1;
      rd_addr = addr_b;
    end else if (state == REQ_R) begin
      rd_req  = 1'b1;
      rd_addr = addr_r;
    end
  end

endmodule

// File: tb/tb_trail_collision.sv
// tb/tb_trail_collision.sv - randomized model-checked bench for trail_collision
module tb_trail_collision;

  localparam logic [2:0] PLAY = 3'b010;

  logic        Clk = 1'b0;
  logic        Reset_n, frame_clk;
  logic [2:0]  Game_State;
  logic [7:0]  Blue_X, Blue_Y, Red_X, Red_Y;
  logic [1:0]  Blue_dir, Red_dir;
  logic        rd_req, rd_gnt, rd_valid;
  logic [19:0] rd_addr;
  logic [15:0] rd_data;
  logic        collision_blue, collision_red, check_done;

  trail_collision dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .Game_State(Game_State),
    .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
    .Blue_dir(Blue_dir), .Red_dir(Red_dir),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .collision_blue(collision_blue), .collision_red(collision_red), .check_done(check_done)
  );

  always #10 Clk = ~Clk;

  typedef struct { int addr_b; int addr_r; bit rd_b; bit rd_r; bit hit_b; bit hit_r; } frame_t;
  typedef struct { bit b; bit r; } flags_t;

  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] mem [int];
  int          exp_addr [$];
  flags_t      exp_done [$];
  bit          exp_b = 0, exp_r = 0;
  int          gnt_hold = 0;
  int          ret_lat  = 1;

  function automatic void chk(string name, int act, int expv);
    vectors++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic logic [15:0] mem_rd(int a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  function automatic bit occupied(logic [15:0] w);
    return (w[3:0] != 0) || (w[11:8] != 0);
  endfunction

  function automatic void step(input int x, input int y, input int d, output int px, output int py);
    px = x; py = y;
    case (d)
      0: py = y - 1;
      1: py = y + 1;
      2: px = x - 1;
      default: px = x + 1;
    endcase
  endfunction

  function automatic bit off_field(int px, int py);
    return px < 0 || px > 223 || py < 0 || py > 223;
  endfunction

  function automatic frame_t model_frame(int bx, int by, int bd, int rx, int ry, int rd);
    frame_t f;
    int pbx, pby, prx, pry;
    bit wb, wr, ob, orr;
    step(bx, by, bd, pbx, pby);
    step(rx, ry, rd, prx, pry);
    wb = off_field(pbx, pby);
    wr = off_field(prx, pry);
    f.addr_b = 2 * pbx + 1280 * pby;
    f.addr_r = 2 * prx + 1280 * pry;
    f.rd_b = !wb;
    f.rd_r = !wr;
    ob = !wb && occupied(mem_rd(f.addr_b));
    orr = !wr && occupied(mem_rd(f.addr_r));
    f.hit_b = wb || ob || (pbx == prx && pby == pry) || (pbx == rx && pby == ry);
    f.hit_r = wr || orr || (pbx == prx && pby == pry) || (prx == bx && pry == by);
    return f;
  endfunction

  // Arbiter and trail-buffer responder.
  initial begin
    int wcnt = 0;
    int rcnt = -1;
    logic [15:0] rdat = 16'h0;
    rd_gnt = 0; rd_valid = 0; rd_data = 0;
    forever begin
      @(negedge Clk);
      rd_gnt = 0; rd_valid = 0; rd_data = 16'($urandom);
      if (!Reset_n) begin
        wcnt = 0; rcnt = -1;
      end else begin
        if (rcnt == 0) begin rd_valid = 1; rd_data = rdat; rcnt = -1; end
        else if (rcnt > 0) rcnt--;
        if (rd_req) begin
          if (wcnt >= gnt_hold) begin
            rd_gnt = 1; wcnt = 0; rdat = mem_rd(int'(rd_addr)); rcnt = ret_lat;
          end else wcnt++;
        end
      end
    end
  end

  // Compare process: protocol, read addresses, completion flags and stickiness every cycle.
  initial begin
    logic p_req = 0, p_gnt = 0, p_b = 0, p_r = 0, p_play = 0;
    logic [19:0] p_addr = 0;
    flags_t f;
    forever begin
      @(negedge Clk); #1;
      if (Reset_n) begin
        if (p_play && p_req && !p_gnt) begin
          chk("req_hold", rd_req, 1);
          chk("addr_hold", rd_addr, p_addr);
        end
        if (p_req && p_gnt) chk("req_drop_after_gnt", rd_req, 0);
        if (!rd_req) chk("addr_idle", rd_addr, 0);
        if (rd_req && rd_gnt) begin
          if (exp_addr.size() == 0) chk("unexpected_read", rd_addr, -1);
          else chk("rd_addr", rd_addr, exp_addr.pop_front());
        end
        if (p_play) begin
          if (p_b) chk("sticky_blue", collision_blue, 1);
          if (p_r) chk("sticky_red", collision_red, 1);
        end else begin
          chk("noplay_blue", collision_blue, 0);
          chk("noplay_red", collision_red, 0);
          chk("noplay_req", rd_req, 0);
        end
        if (check_done) begin
          if (exp_done.size() == 0) chk("spurious_done", 1, 0);
          else begin
            f = exp_done.pop_front();
            chk("done_blue", collision_blue, f.b);
            chk("done_red", collision_red, f.r);
          end
        end
        p_req = rd_req; p_gnt = rd_gnt; p_addr = rd_addr;
        p_b = collision_blue; p_r = collision_red; p_play = (Game_State == PLAY);
      end else begin
        p_req = 0; p_gnt = 0; p_b = 0; p_r = 0; p_play = 0;
      end
    end
  end

  task automatic do_frame(input int bx, input int by, input int bd, input int rx, input int ry,
                          input int rd, input bit second_edge, output frame_t f);
    flags_t e;
    f = model_frame(bx, by, bd, rx, ry, rd);
    @(negedge Clk);
    Blue_X = 8'(bx); Blue_Y = 8'(by); Blue_dir = 2'(bd);
    Red_X = 8'(rx); Red_Y = 8'(ry); Red_dir = 2'(rd);
    if (Game_State == PLAY) begin
      if (f.rd_b) exp_addr.push_back(f.addr_b);
      if (f.rd_r) exp_addr.push_back(f.addr_r);
      exp_b = exp_b | f.hit_b;
      exp_r = exp_r | f.hit_r;
      e.b = exp_b; e.r = exp_r;
      exp_done.push_back(e);
    end
    frame_clk = 1;
    repeat (5) @(negedge Clk);
    Blue_X = 8'($urandom); Blue_Y = 8'($urandom); Red_X = 8'($urandom); Red_Y = 8'($urandom);
    Blue_dir = 2'($urandom); Red_dir = 2'($urandom);
    frame_clk = 0;
    if (second_edge) begin
      repeat (3) @(negedge Clk);
      frame_clk = 1;
      repeat (4) @(negedge Clk);
      frame_clk = 0;
    end
    for (int i = 0; i < 300 && exp_done.size() != 0; i++) @(negedge Clk);
    if (exp_done.size() != 0) begin
      chk("done_timeout", 0, 1);
      exp_done.delete(); exp_addr.delete();
    end
    chk("reads_consumed", exp_addr.size(), 0);
    exp_addr.delete();
    repeat (3) @(negedge Clk);
  endtask

  task automatic leave_play();
    @(negedge Clk);
    Game_State = 3'b000;
    exp_b = 0; exp_r = 0;
    @(negedge Clk);
    chk("clear_blue", collision_blue, 0);
    chk("clear_red", collision_red, 0);
    Game_State = PLAY;
    @(negedge Clk);
  endtask

  function automatic int rnd_coord();
    int edges [6] = '{0, 1, 222, 223, 224, 255};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return $urandom_range(0, 230);
  endfunction

  function automatic logic [15:0] rnd_word();
    logic [15:0] pool [8] = '{16'h0001, 16'h0002, 16'h0300, 16'h0500, 16'h00F0, 16'hF000, 16'h0000, 16'h0104};
    if ($urandom_range(0, 7) == 0) return 16'($urandom);
    return pool[$urandom_range(0, 7)];
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    int bx, by, bd, rx, ry, rd, px, py;
    Reset_n = 0; frame_clk = 0; Game_State = 3'b000;
    Blue_X = 0; Blue_Y = 0; Red_X = 0; Red_Y = 0; Blue_dir = 0; Red_dir = 0;
    #25;
    chk("reset_rd_req", rd_req, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_blue", collision_blue, 0);
    chk("reset_red", collision_red, 0);
    chk("reset_done", check_done, 0);
    @(negedge Clk);
    Reset_n = 1; Game_State = PLAY;
    repeat (3) @(negedge Clk);

    // Empty buffer, both in bounds.
    do_frame(10, 10, 3, 50, 50, 0, 0, f);
    chk("model_addr_b", f.addr_b, 12822);
    chk("model_addr_r", f.addr_r, 62820);
    chk("empty_blue", collision_blue, 0);
    chk("empty_red", collision_red, 0);

    // Blue runs into the right wall.
    do_frame(223, 5, 3, 100, 100, 1, 0, f);
    chk("model_wall_skip", f.rd_b, 0);
    chk("wall_blue", collision_blue, 1);
    chk("wall_red", collision_red, 0);
    leave_play();

    // Red probe onto an occupied cell, then an empty frame, then leave PLAY.
    mem[2 * 60 + 1280 * 61] = 16'h0300;
    do_frame(5, 5, 1, 60, 60, 1, 0, f);
    chk("trail_red", collision_red, 1);
    chk("trail_blue", collision_blue, 0);
    do_frame(5, 5, 1, 80, 80, 0, 0, f);
    chk("sticky_red_frame", collision_red, 1);
    leave_play();
    Game_State = 3'b000;
    do_frame(10, 10, 3, 50, 50, 0, 0, f);
    Game_State = PLAY;

    // Head-on into the same cell.
    do_frame(20, 20, 3, 22, 20, 2, 0, f);
    chk("headon_blue", collision_blue, 1);
    chk("headon_red", collision_red, 1);

    // Reset while waiting for red's data.
    ret_lat = 30;
    @(negedge Clk);
    Blue_X = 30; Blue_Y = 30; Blue_dir = 1; Red_X = 90; Red_Y = 90; Red_dir = 0;
    exp_addr.push_back(2 * 30 + 1280 * 31);
    exp_addr.push_back(2 * 90 + 1280 * 89);
    frame_clk = 1;
    for (int i = 0; i < 100 && exp_addr.size() != 0; i++) @(negedge Clk);
    chk("reads_before_reset", exp_addr.size(), 0);
    frame_clk = 0;
    @(negedge Clk); #3;
    Reset_n = 0;
    #1;
    chk("arst_rd_req", rd_req, 0);
    chk("arst_rd_addr", rd_addr, 0);
    chk("arst_blue", collision_blue, 0);
    chk("arst_red", collision_red, 0);
    chk("arst_done", check_done, 0);
    exp_addr.delete(); exp_done.delete(); exp_b = 0; exp_r = 0;
    ret_lat = 1;
    repeat (2) @(negedge Clk);
    Reset_n = 1;
    repeat (3) @(negedge Clk);

    // Grant withheld 7 cycles with a second frame edge arriving mid-check.
    gnt_hold = 7;
    do_frame(40, 40, 2, 120, 120, 3, 1, f);
    gnt_hold = 0;
    repeat (40) @(negedge Clk);

    // Randomized frames.
    for (int n = 0; n < 60; n++) begin
      gnt_hold = $urandom_range(0, 3);
      ret_lat  = $urandom_range(0, 4);
      bx = rnd_coord(); by = rnd_coord(); bd = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) begin
        rx = (bx + $urandom_range(0, 2)) % 256; ry = by;
      end else begin
        rx = rnd_coord(); ry = rnd_coord();
      end
      rd = $urandom_range(0, 3);
      step(bx, by, bd, px, py);
      if (!off_field(px, py) && $urandom_range(0, 1) == 0) mem[2 * px + 1280 * py] = rnd_word();
      step(rx, ry, rd, px, py);
      if (!off_field(px, py) && $urandom_range(0, 1) == 0) mem[2 * px + 1280 * py] = rnd_word();
      do_frame(bx, by, bd, rx, ry, rd, 0, f);
      if ($urandom_range(0, 4) == 0) leave_play();
    end

    repeat (5) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
